// File: rtl/fsx_timing_mixer_pkg.sv
// Shared types and timing helpers for the frame synthesizer timing generator and mixer.
// Contents: RGB332 pixel struct, line/frame total, counter width and active-window start helpers.
package fsx_timing_mixer_pkg;

    localparam int unsigned RGB_W = 8;

    // Panel colour as carried on layer buses and the output pins.
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Clocks (or lines) in one full period: porches, sync and active region.
    function automatic int unsigned fsx_total(input int unsigned fp, input int unsigned sw,
                                              input int unsigned bp, input int unsigned res);
        return fp + sw + bp + res;
    endfunction

    // Counter width able to hold 0..total-1; never narrower than one bit.
    function automatic int unsigned fsx_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    // The active window is the tail of each period.
    function automatic int unsigned fsx_active_start(input int unsigned total, input int unsigned res);
        return total - res;
    endfunction

endpackage

// File: rtl/fsx_timing_mixer_if.sv
// Coordinate-issue / layer-return bus between the timing mixer and its layer renderers.
// master (mixer): drives o_de/o_h/o_v, receives layer_rgb/layer_valid.
// slave (renderers): the reverse. layer i colour occupies layer_rgb[8i+7:8i].
interface fsx_timing_mixer_if #(
    parameter int unsigned NUM_LAYERS = 2,
    parameter int unsigned HW         = 9,
    parameter int unsigned VW         = 9
);
    logic                      o_de;
    logic [HW-1:0]             o_h;
    logic [VW-1:0]             o_v;
    logic [8*NUM_LAYERS-1:0]   layer_rgb;
    logic [NUM_LAYERS-1:0]     layer_valid;

    modport master (output o_de, o_h, o_v, input layer_rgb, layer_valid);
    modport slave  (input o_de, o_h, o_v, output layer_rgb, layer_valid);
endinterface

// File: rtl/fsx_timing_mixer_delay_line.sv
// Resettable shift register used to align timing strobes with layer return latency.
// Ports: vga_clk, reset (sync, active-high), din/dout WIDTH bits. DEPTH=0 degenerates to a wire.
module fsx_timing_mixer_delay_line #(
    parameter int unsigned       WIDTH     = 4,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{vga_clk, reset};
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] stage;

            // Stage 0 takes the new sample; later stages shift toward dout.
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    stage <= {DEPTH{RESET_VAL}};
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fsx_timing_mixer.sv
// Programmable video timing generator with an N-layer priority pixel mixer driving an RGB332 panel.
// Ports: vga_clk, reset (sync, active-high); layer_en, bg_color; layer_bus (coordinate issue +
// layer return); h_count/v_count raw counters; vga_r/g/b/hs/vs/de panel pins and frameDrawn pulse.
module fsx_timing_mixer
    import fsx_timing_mixer_pkg::*;
#(
    parameter int unsigned H_RES      = 480,
    parameter int unsigned H_FP       = 2,
    parameter int unsigned H_SYNC     = 41,
    parameter int unsigned H_BP       = 2,
    parameter int unsigned V_RES      = 272,
    parameter int unsigned V_FP       = 2,
    parameter int unsigned V_SYNC     = 10,
    parameter int unsigned V_BP       = 2,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned NUM_LAYERS = 2,
    parameter int unsigned LAYER_LAT  = 2,
    localparam int unsigned H_TOTAL   = fsx_total(H_FP, H_SYNC, H_BP, H_RES),
    localparam int unsigned V_TOTAL   = fsx_total(V_FP, V_SYNC, V_BP, V_RES),
    localparam int unsigned HW        = fsx_width(H_TOTAL),
    localparam int unsigned VW        = fsx_width(V_TOTAL)
) (
    input  logic                  vga_clk,
    input  logic                  reset,
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic [RGB_W-1:0]      bg_color,
    fsx_timing_mixer_if.master    layer_bus,
    output logic [HW-1:0]         h_count,
    output logic [VW-1:0]         v_count,
    output logic [2:0]            vga_r,
    output logic [2:0]            vga_g,
    output logic [1:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_de,
    output logic                  frameDrawn
);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ACT        = HW'(fsx_active_start(H_TOTAL, H_RES));
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ACT        = VW'(fsx_active_start(V_TOTAL, V_RES));

    // Delay-line word: {hs, vs, de, eof}; idle value is the inactive level of each strobe.
    localparam int unsigned     DL_W    = 4;
    localparam logic [DL_W-1:0] DL_IDLE = {~H_POL, ~V_POL, 1'b0, 1'b0};

    logic            h_act, v_act, de_raw, hs_raw, vs_raw, eof_raw;
    logic [DL_W-1:0] dl_in, dl_out;
    logic            d_hs, d_vs, d_de, d_eof;
    rgb332_t         mix_c;

    // Raster counters: h wraps every line, v advances on h wrap and wraps per frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + VW'(1);
        end else begin
            h_count <= h_count + HW'(1);
        end
    end

    // Window decode from the raw counters.
    always_comb begin
        h_act   = (h_count >= H_ACT);
        v_act   = (v_count >= V_ACT);
        de_raw  = h_act && v_act;
        hs_raw  = ((h_count >= H_SYNC_START) && (h_count < H_SYNC_END)) ? H_POL : ~H_POL;
        vs_raw  = ((v_count >= V_SYNC_START) && (v_count < V_SYNC_END)) ? V_POL : ~V_POL;
        eof_raw = (h_count == H_LAST) && (v_count == V_LAST);
    end

    // Coordinates handed to renderers are zeroed outside the active window.
    assign layer_bus.o_de = de_raw;
    assign layer_bus.o_h  = de_raw ? (h_count - H_ACT) : '0;
    assign layer_bus.o_v  = de_raw ? (v_count - V_ACT) : '0;

    assign dl_in = {hs_raw, vs_raw, de_raw, eof_raw};

    fsx_timing_mixer_delay_line #(
        .WIDTH     (DL_W),
        .DEPTH     (LAYER_LAT),
        .RESET_VAL (DL_IDLE)
    ) u_delay (
        .vga_clk (vga_clk),
        .reset   (reset),
        .din     (dl_in),
        .dout    (dl_out)
    );

    assign {d_hs, d_vs, d_de, d_eof} = dl_out;

    // Priority mix: scan high to low so the lowest visible index is written last and wins.
    always_comb begin
        mix_c = '0;
        if (d_de) begin
            mix_c = rgb332_t'(bg_color);
            for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                if (layer_en[i] && layer_bus.layer_valid[i]) begin
                    mix_c = rgb332_t'(layer_bus.layer_rgb[RGB_W*i +: RGB_W]);
                end
            end
        end
    end

    // Panel output register; frameDrawn rides alongside the last pixel of the frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vga_hs     <= ~H_POL;
            vga_vs     <= ~V_POL;
            vga_de     <= 1'b0;
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            frameDrawn <= 1'b0;
        end else begin
            vga_hs     <= d_hs;
            vga_vs     <= d_vs;
            vga_de     <= d_de;
            vga_r      <= mix_c.r;
            vga_g      <= mix_c.g;
            vga_b      <= mix_c.b;
            frameDrawn <= d_eof;
        end
    end

endmodule
